// File: rtl/layer_sequencer.sv
// Layer-by-layer controller for the CNN accelerator: walks the fixed five-layer
// LeNet schedule, handshakes host loads, launches each layer and watches for completion.

module layer_seq_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    input  logic flag_i,
    output logic sticky_o
);
    logic sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      sticky_q <= 1'b0;
        else if (clr_i)  sticky_q <= 1'b0;
        else if (en_i)   sticky_q <= sticky_q | flag_i;
    end

    assign sticky_o = sticky_q;
endmodule

module layer_sequencer #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000,
    parameter logic [15:0] CONV1_MASK     = 16'h003F,
    parameter logic [15:0] CONV2_MASK     = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_i,
    input  logic        abort_i,
    input  logic        load_ack_i,
    input  logic [15:0] pool_last_i,
    input  logic        act_last_i,
    output logic [1:0]  start_o,
    output logic [1:0]  nth_o,
    output logic [4:0]  ofmap_size_o,
    output logic [5:0]  ifmap_ch_o,
    output logic [8:0]  in_node_num_o,
    output logic [6:0]  out_node_num_o,
    output logic [2:0]  layer_idx_o,
    output logic        load_req_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);
    localparam int NUM_LANES = 16;

    typedef enum logic [2:0] {
        IDLE, LOAD_REQ, LAUNCH, WAIT_DONE, DONE, ERR
    } state_t;

    typedef struct packed {
        logic [1:0] start;
        logic [1:0] nth;
        logic [4:0] ofmap;
        logic [5:0] ifch;
        logic [8:0] in_node;
        logic [6:0] out_node;
    } cfg_t;

    function automatic cfg_t layer_cfg(input logic [2:0] idx);
        cfg_t c;
        case (idx)
            3'd0:    c = '{2'd1, 2'd0, 5'd28, 6'd1,  9'd0,   7'd0};
            3'd1:    c = '{2'd1, 2'd1, 5'd10, 6'd6,  9'd0,   7'd0};
            3'd2:    c = '{2'd2, 2'd0, 5'd5,  6'd16, 9'd400, 7'd120};
            3'd3:    c = '{2'd2, 2'd1, 5'd5,  6'd16, 9'd120, 7'd84};
            3'd4:    c = '{2'd2, 2'd2, 5'd5,  6'd16, 9'd84,  7'd10};
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [19:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [1:0]  start_q, start_d;
    logic        load_req_q, busy_q, done_q;
    cfg_t        cfg_q;
    logic        sticky_clr, sticky_en, layer_done;
    logic [NUM_LANES-1:0] sticky;
    logic [15:0] mask_sel;

    assign sticky_clr = (state_q == LAUNCH);
    assign sticky_en  = (state_q == WAIT_DONE);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        layer_seq_lane u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr_i    (sticky_clr),
            .en_i     (sticky_en),
            .flag_i   (pool_last_i[l]),
            .sticky_o (sticky[l])
        );
    end

    // Current-cycle flags are folded in so the lane that completes the set counts immediately.
    assign mask_sel   = (idx_q == 3'd0) ? CONV1_MASK : CONV2_MASK;
    assign layer_done = (idx_q < 3'd2) ? (((sticky | pool_last_i) & mask_sel) == mask_sel)
                                       : act_last_i;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE, ERR: begin
                if (run_i) begin
                    state_d = LOAD_REQ;
                    idx_d   = 3'd0;
                    err_d   = 1'b0;
                end
            end
            LOAD_REQ: if (load_ack_i) state_d = LAUNCH;
            LAUNCH: begin
                state_d = WAIT_DONE;
                cnt_d   = '0;
            end
            WAIT_DONE: begin
                if (layer_done) begin
                    if (idx_q == 3'd4) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD_REQ;
                        idx_d   = idx_q + 3'd1;
                    end
                // Expiry decided one cycle early so err_o lands TIMEOUT_CYCLES after start.
                end else if (cnt_q == TIMEOUT_CYCLES - 20'd2) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d = IDLE;
            idx_d   = 3'd0;
            err_d   = err_q;
        end
        start_d = (state_d == LAUNCH) ? cfg_q.start : 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            start_q    <= 2'd0;
            load_req_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            start_q    <= start_d;
            load_req_q <= (state_d == LOAD_REQ);
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == DONE);
            if (state_d == LOAD_REQ && state_q != LOAD_REQ)
                cfg_q <= layer_cfg(idx_d);
        end
    end

    assign start_o        = start_q;
    assign nth_o          = cfg_q.nth;
    assign ofmap_size_o   = cfg_q.ofmap;
    assign ifmap_ch_o     = cfg_q.ifch;
    assign in_node_num_o  = cfg_q.in_node;
    assign out_node_num_o = cfg_q.out_node;
    assign layer_idx_o    = idx_q;
    assign load_req_o     = load_req_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: a long-timeout instance for schedule tests and a
// TIMEOUT_CYCLES=16 instance for watchdog tests, both fed from the same stimulus.
module tb_layer_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        run_i = 1'b0, abort_i = 1'b0, load_ack_i = 1'b0, act_last_i = 1'b0;
    logic [15:0] pool_last_i = '0;

    logic [1:0] start_o, nth_o, t_start, t_nth;
    logic [4:0] ofmap_size_o, t_ofmap;
    logic [5:0] ifmap_ch_o, t_ifch;
    logic [8:0] in_node_num_o, t_in;
    logic [6:0] out_node_num_o, t_out;
    logic [2:0] layer_idx_o, t_idx;
    logic       load_req_o, busy_o, done_o, err_o;
    logic       t_load_req, t_busy, t_done, t_err;

    int checks = 0;
    int errors = 0;

    int          e_start[5] = '{1, 1, 2, 2, 2};
    int          e_nth[5]   = '{0, 1, 0, 1, 2};
    int          e_ofmap[5] = '{28, 10, 5, 5, 5};
    int          e_ifch[5]  = '{1, 6, 16, 16, 16};
    int          e_in[5]    = '{0, 0, 400, 120, 84};
    int          e_out[5]   = '{0, 0, 120, 84, 10};
    logic [15:0] e_mask[2]  = '{16'h003F, 16'hFFFF};

    always #5 clk = ~clk;

    layer_sequencer #(.TIMEOUT_CYCLES(20'd64)) dut (
        .clk(clk), .rst_n(rst_n), .run_i(run_i), .abort_i(abort_i),
        .load_ack_i(load_ack_i), .pool_last_i(pool_last_i), .act_last_i(act_last_i),
        .start_o(start_o), .nth_o(nth_o), .ofmap_size_o(ofmap_size_o),
        .ifmap_ch_o(ifmap_ch_o), .in_node_num_o(in_node_num_o),
        .out_node_num_o(out_node_num_o), .layer_idx_o(layer_idx_o),
        .load_req_o(load_req_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    layer_sequencer #(.TIMEOUT_CYCLES(20'd16)) dut_to (
        .clk(clk), .rst_n(rst_n), .run_i(run_i), .abort_i(abort_i),
        .load_ack_i(load_ack_i), .pool_last_i(pool_last_i), .act_last_i(act_last_i),
        .start_o(t_start), .nth_o(t_nth), .ofmap_size_o(t_ofmap),
        .ifmap_ch_o(t_ifch), .in_node_num_o(t_in),
        .out_node_num_o(t_out), .layer_idx_o(t_idx),
        .load_req_o(t_load_req), .busy_o(t_busy), .done_o(t_done), .err_o(t_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ack in LOAD_REQ, then complete on the first WAIT_DONE cycle.
    task automatic fast_layer(input logic conv, input logic [15:0] m);
        load_ack_i = 1'b1; step(); load_ack_i = 1'b0;
        step();
        if (conv) pool_last_i = m; else act_last_i = 1'b1;
        step();
        pool_last_i = '0; act_last_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; step(); step(); rst_n = 1'b1; step();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_start"}, start_o, 0);      chk({tag, "_nth"}, nth_o, 0);
        chk({tag, "_ofmap"}, ofmap_size_o, 0); chk({tag, "_ifch"}, ifmap_ch_o, 0);
        chk({tag, "_in"}, in_node_num_o, 0);   chk({tag, "_out"}, out_node_num_o, 0);
        chk({tag, "_idx"}, layer_idx_o, 0);    chk({tag, "_lreq"}, load_req_o, 0);
        chk({tag, "_busy"}, busy_o, 0);        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_t_lreq"}, t_load_req, 0);  chk({tag, "_t_err"}, t_err, 0);
    endtask

    initial begin
        // Reset values
        rst_n = 1'b0; step(); step();
        chk_zero("rst");
        rst_n = 1'b1; step();

        // Full network run, acking each load after 3 cycles
        run_i = 1'b1; step(); run_i = 1'b0;
        for (int l = 0; l < 5; l++) begin
            chk("full_lreq", load_req_o, 1);   chk("full_idx", layer_idx_o, l);
            chk("full_nth", nth_o, e_nth[l]);  chk("full_ofmap", ofmap_size_o, e_ofmap[l]);
            chk("full_ifch", ifmap_ch_o, e_ifch[l]);
            chk("full_in", in_node_num_o, e_in[l]); chk("full_out", out_node_num_o, e_out[l]);
            run_i = (l == 2);
            repeat (3) step();
            run_i = 1'b0;
            chk("full_lreq_hold", load_req_o, 1); chk("full_idx_hold", layer_idx_o, l);
            chk("full_start_wait", start_o, 0);
            load_ack_i = 1'b1; step(); load_ack_i = 1'b0;
            chk("full_start", start_o, e_start[l]); chk("full_lreq_off", load_req_o, 0);
            step();
            chk("full_start_pulse", start_o, 0);
            if (l < 2) pool_last_i = e_mask[l]; else act_last_i = 1'b1;
            step();
            pool_last_i = '0; act_last_i = 1'b0;
        end
        chk("full_done", done_o, 1); chk("full_busy_done", busy_o, 1);
        step();
        chk("full_done_pulse", done_o, 0); chk("full_busy_end", busy_o, 0);
        chk("full_err", err_o, 0);
        chk("full_in_hold", in_node_num_o, 84); chk("full_out_hold", out_node_num_o, 10);

        // Staggered lanes in conv2, with flags pulsed during LAUNCH
        run_i = 1'b1; step(); run_i = 1'b0;
        fast_layer(1'b1, 16'h003F);
        chk("stag_idx1", layer_idx_o, 1);
        load_ack_i = 1'b1; step(); load_ack_i = 1'b0;
        chk("stag_launch", start_o, 1);
        pool_last_i = 16'hFFFF; step(); pool_last_i = '0;
        chk("stag_launch_ign_lreq", load_req_o, 0); chk("stag_launch_ign_idx", layer_idx_o, 1);
        for (int i = 0; i < 16; i++) begin
            pool_last_i = 16'h0001 << i;
            step();
            if (i < 15) chk("stag_noadv", layer_idx_o, 1);
        end
        pool_last_i = '0;
        chk("stag_adv_idx", layer_idx_o, 2); chk("stag_adv_lreq", load_req_o, 1);
        chk("stag_adv_in", in_node_num_o, 400);

        // Abort during WAIT_DONE of fc2
        fast_layer(1'b0, '0);
        chk("abt_idx3", layer_idx_o, 3);
        load_ack_i = 1'b1; step(); load_ack_i = 1'b0;
        step(); step();
        chk("abt_wait_busy", busy_o, 1); chk("abt_wait_lreq", load_req_o, 0);
        abort_i = 1'b1; step(); abort_i = 1'b0;
        chk("abt_busy", busy_o, 0); chk("abt_start", start_o, 0);
        chk("abt_idx", layer_idx_o, 0); chk("abt_lreq", load_req_o, 0);
        act_last_i = 1'b1; step(); act_last_i = 1'b0;
        chk("abt_late_busy", busy_o, 0); chk("abt_late_done", done_o, 0);
        chk("abt_late_lreq", load_req_o, 0);

        // Timeout on conv1 with TIMEOUT_CYCLES=16
        do_reset();
        run_i = 1'b1; step(); run_i = 1'b0;
        chk("to_lreq", t_load_req, 1);
        load_ack_i = 1'b1; step(); load_ack_i = 1'b0;
        chk("to_start", t_start, 1);
        repeat (15) step();
        chk("to_err_early", t_err, 0); chk("to_busy_early", t_busy, 1);
        step();
        chk("to_err", t_err, 1); chk("to_err_start", t_start, 0);
        chk("to_err_lreq", t_load_req, 0); chk("to_err_busy", t_busy, 1);
        step();
        chk("to_err_sticky", t_err, 1);
        run_i = 1'b1; step(); run_i = 1'b0;
        chk("to_rerun_err", t_err, 0); chk("to_rerun_lreq", t_load_req, 1);
        chk("to_rerun_idx", t_idx, 0); chk("to_rerun_ofmap", t_ofmap, 28);

        // Done coincides with timeout expiry on fc1
        fast_layer(1'b1, 16'h003F);
        fast_layer(1'b1, 16'hFFFF);
        chk("co_idx2", t_idx, 2);
        load_ack_i = 1'b1; step(); load_ack_i = 1'b0;
        chk("co_start", t_start, 2);
        repeat (15) step();
        act_last_i = 1'b1; step(); act_last_i = 1'b0;
        chk("co_idx", t_idx, 3); chk("co_lreq", t_load_req, 1);
        chk("co_err", t_err, 0); chk("co_in", t_in, 120); chk("co_out", t_out, 84);

        // Abort from ERR keeps err_o set
        do_reset();
        run_i = 1'b1; step(); run_i = 1'b0;
        load_ack_i = 1'b1; step(); load_ack_i = 1'b0;
        repeat (16) step();
        chk("ea_err", t_err, 1);
        abort_i = 1'b1; step(); abort_i = 1'b0;
        chk("ea_err_kept", t_err, 1); chk("ea_busy", t_busy, 0);

        // Asynchronous reset mid-LOAD_REQ
        do_reset();
        run_i = 1'b1; step(); run_i = 1'b0;
        chk("ar_lreq_before", load_req_o, 1); chk("ar_ofmap_before", ofmap_size_o, 28);
        #3 rst_n = 1'b0;
        #1 chk_zero("ar");
        step(); rst_n = 1'b1; step();
        run_i = 1'b1; step(); run_i = 1'b0;
        chk("ar_rerun_lreq", load_req_o, 1); chk("ar_rerun_idx", layer_idx_o, 0);
        chk("ar_rerun_ofmap", ofmap_size_o, 28); chk("ar_rerun_ifch", ifmap_ch_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
